// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and engine state encoding.
// Constant multipliers are built from xtime chains only.
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmulB(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmulD(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmulE(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_mixcol_engine_if.sv
// Handshake bundle of the MixColumns engine.
// master = upstream/downstream side, slave = engine.
interface aes_mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_mixcol_engine_word.sv
// Combinational single-column MixColumns / InvMixColumns.
// Row 0 of the column sits in bits [31:24].
module aes_mixcol_word
  import aes_pkg::*;
#(
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd;

  assign {a0, a1, a2, a3} = col;

  assign fwd = {
    gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
    a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
    a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
    gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)
  };

  if (SUPPORT_INV) begin : g_inv
    logic [31:0] ivs;
    assign ivs = {
      gmulE(a0) ^ gmulB(a1) ^ gmulD(a2) ^ gmul9(a3),
      gmul9(a0) ^ gmulE(a1) ^ gmulB(a2) ^ gmulD(a3),
      gmulD(a0) ^ gmul9(a1) ^ gmulE(a2) ^ gmulB(a3),
      gmulB(a0) ^ gmulD(a1) ^ gmul9(a2) ^ gmulE(a3)
    };
    assign res = inv ? ivs : fwd;
  end else begin : g_fwd
    logic unused_inv;
    assign unused_inv = inv;
    assign res = fwd;
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// Iterative MixColumns engine: COLS_PER_CYCLE columns per clock,
// rewritten in place in the state register, MSW column first.
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit SUPPORT_INV    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  aes_mixcol_engine_if.slave bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [127:0]    data_q, data_nxt;
  logic            inv_q;
  logic            last;
  logic [6:0]      lsb     [COLS_PER_CYCLE];
  logic [31:0]     col_in  [COLS_PER_CYCLE];
  logic [31:0]     col_out [COLS_PER_CYCLE];

  assign last = (cnt == CW'(NCYC - 1));

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      lsb[k] = 7'(96 - 32 * (int'(cnt) * COLS_PER_CYCLE + k));
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_in[k] = data_q[lsb[k] +: 32];
    aes_mixcol_word #(.SUPPORT_INV(SUPPORT_INV)) u_word (
      .col (col_in[k]),
      .inv (inv_q),
      .res (col_out[k])
    );
  end

  always_comb begin
    data_nxt = data_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      data_nxt[lsb[k] +: 32] = col_out[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid)
              state_nxt = bus.in_bypass ? DONE : BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt    <= '0;
      inv_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        data_q <= bus.in_data;
        inv_q  <= SUPPORT_INV && bus.in_inv;
      end
      if (state == BUSY) begin
        data_q <= data_nxt;
        cnt    <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  assign bus.out_data = data_q;

endmodule

// File: doc/aes_mixcol_engine.md
Name: aes_mixcol_engine

Overview:
Parametrised, handshaked AES MixColumns/InvMixColumns engine for the iterative AES datapath.
- Transforms one 128-bit state per transaction.
- Processes COLS_PER_CYCLE columns per clock, so area can be traded against latency.
- Supports forward mode (encrypt), inverse mode (decrypt) and bypass (final round).
- Sits between ShiftRows/InvShiftRows and AddRoundKey, using valid/ready handshakes on both sides.

Parameters:
- COLS_PER_CYCLE, default 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- SUPPORT_INV, default 1: 1 instantiates the inverse matrix. When 0, in_inv is ignored and forward mode is always used.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept an input.
- in_data  in  128  state; column c = bits[127-32c -: 32]; within a column, row 0 = bits[31:24].
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns; sampled at acceptance.
- in_bypass  in  1  1 = pass state unchanged (final round); sampled at acceptance.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  transformed state.

Behaviour:
- Reset: when rst_n=0 at a clock edge, go to IDLE and set in_ready=1, out_valid=0, out_data=0, column counter=0.
- Reset mid-operation: an in-flight transaction is discarded with no output.
- NCYC = 4/COLS_PER_CYCLE.
- IDLE: in_ready=1.
  - in_valid&&in_ready captures in_data, in_inv and in_bypass into the state register.
  - Next state is BUSY, or DONE if in_bypass=1.
- BUSY: in_ready=0.
  - Each cycle replaces columns cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 in place; column 0 (MSW) is done first.
  - cnt increments each cycle. At cnt=NCYC-1, cnt wraps to 0 and the next state is DONE.
- DONE: out_valid=1, in_ready=0.
  - out_data equals the state register and stays stable while out_ready=0.
  - out_valid&&out_ready returns to IDLE.
- Latency:
  - Acceptance at edge T gives out_valid high after edge T+NCYC.
  - Bypass gives out_valid high after edge T+1.
- Throughput: no overlap; in_ready is never 1 while out_valid=1. Sustained rate is one state per NCYC+2 cycles with out_ready tied high.
- Signals outside DONE:
  - out_data keeps its last value outside DONE but is only meaningful while out_valid=1.
  - in_inv and in_bypass are ignored except at acceptance.
- Arithmetic, GF(2^8) with polynomial x^8+x^4+x^3+x+1 (reduction 0x1B):
  - Forward circulant row: {02,03,01,01}.
  - Inverse circulant row: {0E,0B,0D,09}.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).
  - Multiply-by-constant uses xtime chains only; no multipliers or LUTs.
- All outputs are registered: out_data comes from the state register, and out_valid/in_ready decode directly from state flops.

Decomposition:
- Shared package aes_pkg:
  - constant AES_POLY_RED = 8'h1B.
  - function xtime.
  - functions gmul2, gmul3, gmul9, gmulB, gmulD, gmulE.
  - state enum {IDLE, BUSY, DONE}.
- Sub-module aes_mixcol_word:
  - Purely combinational 32-bit column transform with an inv input.
  - Instantiated COLS_PER_CYCLE times.
  - Its inverse path is generated only when SUPPORT_INV=1.
- Column selection uses a mux on cnt; write-back is an indexed part-select of the state register.

Test Plan:
1. FIPS-197 forward, COLS_PER_CYCLE=1. Input d4bf5d30e0b452aeb84111f11e2798e5, inv=0 -> out_data 046681e5e0cb199a48f8d37a2806264c, with out_valid rising 4 cycles after acceptance.
2. Inverse round-trip. Input 046681e5e0cb199a48f8d37a2806264c, inv=1 -> d4bf5d30e0b452aeb84111f11e2798e5.
3. Single-column vectors, forward:
   - db135345 -> 8e4da1bc
   - f20a225c -> 9fdc589d
   - c6c6c6c6 -> c6c6c6c6
   - d4d4d4d5 -> d5d5d7d6
   - 2d26314c -> 4d7ebdf8
   Each vector is placed in all four columns, and each must also invert back with inv=1.
4. Bypass and backpressure:
   - bypass=1 with arbitrary data -> identical out_data one cycle after acceptance.
   - Hold out_ready=0 for 5 cycles -> out_data stable, out_valid=1, in_ready=0, and in_valid is ignored.
5. Reset mid-BUSY: drop rst_n at cnt=2 -> next cycle in_ready=1, out_valid=0, out_data=0. A fresh transaction then completes correctly.
6. Parameter sweep: COLS_PER_CYCLE=2 and 4 with vector 1 -> same result, latency 2 and 1 cycles. SUPPORT_INV=0 with inv=1 -> forward result.
